// File: rtl/cq_viola_dipsw_debounce.sv
// DIP-switch synchronizer and per-bit debouncer for the Viola PIO in_port.
// Emits a registered one-cycle change pulse with a per-bit mask.
module cq_viola_dipsw_debounce #(
  parameter int               WIDTH         = 10,
  parameter int               STABLE_CYCLES = 50000,
  parameter int               CNT_W         = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic [WIDTH-1:0] changed_mask
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic             r_chg;
  logic [WIDTH-1:0] r_mask;

  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_flag;

  // Per-bit stability count: restart on agreement, accept at the last count
  always_comb begin
    w_out_nxt = r_out;
    w_flag    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_out[i]) begin
        if (r_cnt[i] == LP_LAST) begin
          w_out_nxt[i] = r_sync2[i];
          w_flag[i]    = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + LP_ONE;
        end
      end
    end
  end

  // Synchronizer, counters, accepted level and registered change flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
      r_out   <= RESET_VALUE;
      r_chg   <= 1'b0;
      r_mask  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      r_out   <= w_out_nxt;
      r_chg   <= |w_flag;
      r_mask  <= w_flag;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign sw_out       = r_out;
  assign changed      = r_chg;
  assign changed_mask = r_mask;

endmodule

// File: doc/cq_viola_dipsw_debounce.md
# cq_viola_dipsw_debounce

Synchronizes and debounces the raw DIP-switch pins before they reach the Avalon PIO input port on the Viola system bus. Each bit passes through a two-flop synchronizer and a per-bit stability counter. The debounced vector drives the PIO `in_port` directly. A one-cycle change pulse with a per-bit mask is also provided for interrupt or edge-capture logic.

## Interface
Parameters:
- `WIDTH`, 10, number of switch bits.
- `STABLE_CYCLES`, 50000, consecutive disagreeing synchronized samples required to accept a new level (1 ms at 50 MHz). Must be ≥ 1.
- `CNT_W`, 16, stability counter width. Must satisfy 2^CNT_W ≥ STABLE_CYCLES.
- `RESET_VALUE`, {WIDTH{1'b0}}, value of the synchronizer flops and `sw_out` in reset.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sw_in`  in  WIDTH  raw asynchronous switch pins.
- `sw_out`  out  WIDTH  debounced switch state; feeds the PIO `in_port`.
- `changed`  out  1  one-cycle pulse when any bit of `sw_out` updates.
- `changed_mask`  out  WIDTH  bits that updated in the `changed` cycle; all zero otherwise.

## Operation
- Synchronizer: `sync1 <= sw_in`, `sync2 <= sync1`, per bit. Reset loads `RESET_VALUE` into both stages.
- Per-bit counter `cnt[i]` (CNT_W bits), evaluated on every edge:
  - If `sync2[i] == sw_out[i]`: set `cnt[i] <= 0`. Any glitch back to the accepted level restarts the interval.
  - Else, if `cnt[i] == STABLE_CYCLES-1`: set `sw_out[i] <= sync2[i]` and `cnt[i] <= 0`, and flag bit i as changed.
  - Else: set `cnt[i] <= cnt[i] + 1`.
- The counter never exceeds STABLE_CYCLES-1, so it cannot wrap.
- Bits are fully independent. Any number of bits may qualify on the same edge.
- `changed_mask` is a registered copy of the per-bit flags from that edge. `changed` is the OR of those flags, also registered. Both are cleared on the next edge unless a new update occurs.
- Reset behaviour (any time, including mid-debounce): on the reset edge, `sync1`, `sync2`, and `sw_out` load `RESET_VALUE`; every `cnt` clears to 0; `changed` and `changed_mask` clear to 0. Any partial interval is discarded.

## Timing
- Output reset values: `sw_out` = `RESET_VALUE`, `changed` = 0, `changed_mask` = 0.
- Latency: let E0 be the edge at which `sync1` first captures a new level, with the level held steady afterward.
  - E0+1: `sync2` holds the new level.
  - E0+2 … E0+1+STABLE_CYCLES: counter counts.
  - E0+1+STABLE_CYCLES: `sw_out`, `changed`, and `changed_mask` update together.
  - Total latency is STABLE_CYCLES+1 edges after E0.
- With STABLE_CYCLES = 1, `sw_out` updates at E0+2.
- `changed` is high for exactly one cycle per update edge. If updates occur on back-to-back edges (different bits), `changed` stays high for consecutive cycles, each with its own mask.
- No handshake: `sw_out` is level data, sampled by the PIO every cycle.

## Test plan
Benches run with STABLE_CYCLES = 4 and WIDTH = 10.
- **Reset with switches on.** Hold `reset` for 3 cycles with `sw_in` = 10'h3FF. Required: `sw_out` = 0 and `changed` = 0 throughout reset. Taking the first edge with `reset` low as E0, `sw_out` = 10'h3FF after E0+5, with a single `changed` pulse and `changed_mask` = 10'h3FF.
- **Clean step.** Bit 3 steps 0→1 and stays. Required: `sw_out[3]` rises exactly 5 edges after `sync1` captures it; one `changed` pulse with `changed_mask` = 10'h008; no other bits move.
- **Short glitch.** Bit 0 is high for 3 cycles, then returns low. Required: `sw_out` unchanged and `changed` never asserts.
- **Bounce.** Bit 7 toggles every 2 cycles for 20 cycles, then holds high. Required: exactly one 0→1 transition on `sw_out[7]`, at 5 edges after the final level is captured; exactly one `changed` pulse with `changed_mask` = 10'h080.
- **Simultaneous.** Bits 1 and 9 change on the same cycle. Required: both update on the same edge; a single `changed` pulse with `changed_mask` = 10'h202.
- **Reset mid-debounce.** Bit 2 goes high; assert `reset` for 1 cycle when `cnt[2]` = 2. Required: `sw_out[2]` stays 0 and no `changed` pulse occurs. After release, the full interval restarts, and `sw_out[2]` rises 5 edges after the post-reset capture edge.
